// File: rtl/fifo_rdr_pkg.sv
// +----------------------------------------------------------------------+
// | fifo_rdr_pkg : shared types and defaults for fifo_stream_reader      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package fifo_rdr_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

`default_nettype wire

// File: rtl/fifo_rdr_if.sv
// +----------------------------------------------------------------------+
// | fifo_rdr_if : FIFO read port plus valid/ready output stream          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface fifo_rdr_if
  import fifo_rdr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

`default_nettype wire

// File: rtl/fifo_rdr_buf2.sv
// +----------------------------------------------------------------------+
// | fifo_rdr_buf2 : 2-entry ordered buffer, registered head              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_rdr_buf2
  import fifo_rdr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output occ_e             occ_o
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      ent1_q <= ent1_d;
    end
  end

  // Push into a full buffer is prevented by the issue logic upstream.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    ent1_d = ent1_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          head_d = push_data_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({push_i, pop_i})
          2'b11: head_d = push_data_i;
          2'b10: begin
            ent1_d = push_data_i;
            occ_d  = OCC_TWO;
          end
          2'b01: occ_d = OCC_EMPTY;
          default: ;
        endcase
      end
      OCC_TWO: begin
        if (pop_i) begin
          head_d = ent1_q;
          if (push_i) ent1_d = push_data_i;
          else        occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign head_o = head_q;
  assign occ_o  = occ_q;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// +----------------------------------------------------------------------+
// | fifo_stream_reader : drains a 1-cycle-latency FIFO onto valid/ready  |
// | Optional transfer counter: define FIFO_RDR_STATS_EN                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_stream_reader
  import fifo_rdr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef FIFO_RDR_STATS_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  fifo_rdr_if.master       bus
`ifdef FIFO_RDR_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count
`endif
);

  logic             inflight_q;
  logic             pop;
  logic             rd_en;
  logic [2:0]       level;
  logic [2:0]       limit;
  occ_e             occ;
  logic [WIDTH-1:0] head;

  assign pop = bus.m_valid & bus.m_ready;

  // Words already held or in flight must fit once this cycle's pop frees a slot.
  assign level = {1'b0, occ} + {2'b00, inflight_q};
  assign limit = 3'd2 + {2'b00, pop};
  assign rd_en = !rst & !bus.fifo_empty & (level < limit);

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= rd_en;
  end

  fifo_rdr_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (bus.fifo_dout),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != OCC_EMPTY);
  assign bus.m_data     = head;

`ifdef FIFO_RDR_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)      cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign xfer_count = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// +----------------------------------------------------------------------+
// | tb_fifo_stream_reader : scoreboard bench with a behavioural FIFO     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fifo_stream_reader;
  import fifo_rdr_pkg::*;

  localparam int WIDTH = 8;
`ifdef FIFO_RDR_STATS_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] xfer_count;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rdr_if #(.WIDTH(WIDTH)) bus ();

  fifo_stream_reader #(
    .WIDTH (WIDTH)
`ifdef FIFO_RDR_STATS_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_RDR_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  int n_checks = 0;
  int n_fails  = 0;
  int beats    = 0;
  int rd_pulses = 0;
  int exp_cnt  = 0;

  // Behavioural FIFO: registered dout, one-cycle read latency, flushed by rst.
  logic [WIDTH-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [WIDTH-1:0] ready_r = 1'b0;
  logic [WIDTH-1:0] dout_r  = '0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_dout  = dout_r;
  assign bus.m_ready    = ready_r[0];

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      dout_r <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [WIDTH-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.fifo_rd_en) rd_pulses++;
      chk("rd_en_while_empty", {31'd0, bus.fifo_rd_en & bus.fifo_empty}, 32'd0);
      chk("occ_le_2", {31'd0, (int'(dut.u_buf.occ_q) > 2)}, 32'd0);
      if (prev_stall) begin
        chk("hold_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("hold_data", {24'd0, bus.m_data}, {24'd0, prev_data});
      end
`ifdef FIFO_RDR_STATS_EN
      chk("xfer_count", {28'd0, xfer_count}, exp_cnt % 16);
`endif
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", {24'd0, bus.m_data}, 32'hFFFF_FFFF);
        end else begin
          chk("beat_data", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
        end
        beats++;
        exp_cnt++;
      end
      prev_stall = bus.m_valid & !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic drain(input int budget, input bool_rand);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && i < budget) begin
      step();
      if (bool_rand) ready_r = {7'd0, ($urandom_range(0, 99) < 30)};
      i++;
    end
    chk("drain_done", exp_q.size(), 32'd0);
    ready_r = 1'b1;
  endtask

  initial begin
    int r0, b0, sent, guard;

    // Reset state
    ready_r = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, bus.m_data}, 32'd0);
    chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    step();
    rst = 1'b0;

    // Reset in the middle of traffic
    ready_r = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h21 + 8'(i));
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("midrst_m_data", {24'd0, bus.m_data}, 32'd0);
    chk("midrst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
`ifdef FIFO_RDR_STATS_EN
    chk("midrst_xfer", {28'd0, xfer_count}, 32'd0);
`endif
    step();
    rst = 1'b0;
    r0 = rd_pulses;
    repeat (3) step();
    chk("post_rst_idle_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("post_rst_no_reads", rd_pulses - r0, 32'd0);

    // Preloaded burst at full throughput
    r0 = rd_pulses; b0 = beats;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    @(negedge clk);
    chk("first_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
    @(negedge clk);
    chk("lat_cycle1_valid", {31'd0, bus.m_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", {31'd0, bus.m_valid}, 32'd1);
    end
    @(negedge clk);
    chk("stream_end_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("burst_beats", beats - b0, 32'd8);
    chk("burst_reads", rd_pulses - r0, 32'd8);

    // Backpressure: only two words leave the FIFO
    step();
    ready_r = 1'b0;
    r0 = rd_pulses; b0 = beats;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    repeat (8) @(negedge clk);
    chk("bp_reads", rd_pulses - r0, 32'd2);
    chk("bp_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("bp_head", {24'd0, bus.m_data}, 32'h11);
    step();
    ready_r = 1'b1;
    drain(40, 1'b0);
    chk("bp_total_reads", rd_pulses - r0, 32'd8);
    chk("bp_total_beats", beats - b0, 32'd8);

    // Single word
    step();
    r0 = rd_pulses; b0 = beats;
    push(8'h5A);
    repeat (6) step();
    chk("single_reads", rd_pulses - r0, 32'd1);
    chk("single_beats", beats - b0, 32'd1);
    chk("single_idle", {31'd0, bus.m_valid}, 32'd0);

    // Random traffic with 30% ready
    b0 = beats; sent = 0; guard = 0;
    while (sent < 200 && guard < 5000) begin
      step();
      ready_r = {7'd0, ($urandom_range(0, 99) < 30)};
      if ($urandom_range(0, 1) == 1) begin
        push(8'($urandom_range(0, 255)));
        sent++;
      end
      guard++;
    end
    drain(3000, 1'b1);
    chk("random_beats", beats - b0, 32'd200);

`ifdef FIFO_RDR_STATS_EN
    // Counter wrap at 2^CNT_W
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    ready_r = 1'b1;
    for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
    drain(100, 1'b0);
    step();
    chk("xfer_wrap", {28'd0, xfer_count}, 32'd1);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
